starship_repair_lock: RTL and testbench
=======================================

// Module: starship_repair_lock
// PURPOSE
//  Verifier for the player's hex repair entry. When a station reports broken,
//  it draws a 4-digit hex repair code from a free-running LFSR and publishes it
//  for the SSDs. It then consumes the nibbles the top level captures from Sw3..Sw0
//  on each debounced Center pulse. The block checks them in order and pulses
//  repaired on a full correct match. Wrong digits and timeouts restart entry.
// PARAMETERS
//  NDIG       4          digits per code (code width = 4*NDIG)
//  LFSR_SEED  16'hACE1   LFSR reset value; a value of 0 is replaced by 16'h0001
//  TIMEOUT    32'd500_000_000  cycles allowed per code (5 s at 100 MHz), >=1
// PORTS
//  board_clk    in   1   100 MHz system clock
//  Reset        in   1   asynchronous, active-high (BtnC)
//  broken       in   1   level from station SM; its rising edge arms a repair
//  digit_valid  in   1   single-cycle pulse; digit is sampled this cycle
//  digit        in   4   entered nibble {Sw3,Sw2,Sw1,Sw0}
//  code         out  16  target code; digit 0 = code[15:12], digit 3 = code[3:0]
//  entered      out  16  correct digits so far, shifted in at LSB, zero-filled
//  entry_count  out  3   correct digits so far, 0..NDIG
//  busy         out  1   high while in ARMED
//  repaired     out  1   1-cycle pulse: code fully matched
//  error        out  1   1-cycle pulse: wrong digit
//  timed_out    out  1   1-cycle pulse: TIMEOUT expired, new code issued
// BEHAVIOUR
//  - Reset: state=IDLE, lfsr=LFSR_SEED (or 1), broken_d=0, timer=0.
//    code, entered, entry_count, busy, repaired, error and timed_out are all 0.
//  - LFSR: 16-bit Galois, mask 16'hB400. Every cycle, including IDLE:
//    lfsr <= lfsr[0] ? (lfsr>>1)^16'hB400 : lfsr>>1. It is never 0.
//  - Arm: broken_d is broken registered; arm = broken & ~broken_d. broken held
//    high through reset release therefore arms on the first clock.
//  - IDLE: on arm -> code<=lfsr (pre-step value), entered<=0, entry_count<=0,
//    timer<=TIMEOUT-1, state->ARMED. digit_valid is ignored in IDLE.
//  - ARMED, priority highest first:
//    1. broken==0: abort -> IDLE. entered and entry_count cleared, code holds,
//       no pulse.
//    2. timer==0: timed_out=1, code<=lfsr, entered<=0, entry_count<=0,
//       timer<=TIMEOUT-1. A digit_valid in this same cycle is dropped.
//    3. digit_valid & digit==code[4*(NDIG-1-entry_count)+:4]: entered<=
//       {entered[11:0],digit}, entry_count++.
//       If this is digit NDIG: repaired=1, state->IDLE, entered and code hold.
//       Otherwise timer decrements.
//    4. digit_valid & mismatch: error=1, entered<=0, entry_count<=0, timer keeps
//       counting (it is not reloaded).
//    5. else timer decrements.
//  - All outputs are registered. Pulses go high in the cycle after the sampling
//    edge and last exactly one cycle.
//  - After repaired the block returns to IDLE. broken must fall and rise again
//    to re-arm; the station SM drops broken on repaired.
//  - Reset mid-entry returns everything to reset values at once.
// TESTING
//  1 LFSR_SEED=16'h0001: lfsr steps 0001 -> B400 -> 5A00. Raise broken on the
//    edge where lfsr=B400 -> code=16'hB400, busy=1 next cycle.
//  2 code=16'h3A7F: digits 3,A,7,F on 4 separate pulses -> entry_count 1,2,3,
//    entered=16'h3A7F, repaired high 1 cycle, busy=0.
//  3 code=16'h3A7F: digits 3,A,5 -> error pulse on the 5, entry_count=0,
//    entered=0. Then 3,A,7,F -> repaired.
//  4 TIMEOUT=10: arm, send no digits -> timed_out 10 cycles after arm, new code
//    = lfsr value, still busy. digit_valid in the expiry cycle is ignored.
//  5 Abort and IDLE: broken falls after 2 correct digits -> IDLE, entry_count=0,
//    no pulse. Pulses in IDLE change nothing.
//  6 Reset asserted during ARMED with entry_count=2 -> all outputs 0 immediately
//    (asynchronous), state=IDLE.

Source files
------------

// File: rtl/starship_repair_lock_if.sv
// rtl/starship_repair_lock_if.sv - digit entry / code status bundle for the repair lock
//
// Purpose: groups the repair-lock stimulus and status signals into one port.
//   master: the top level / station side (drives broken and digit entries)
//   slave : the repair lock itself (publishes code and entry status)
// Signals:
//   broken       station broken level, rising edge arms a repair
//   digit_valid  single-cycle entry strobe
//   digit        entered nibble {Sw3,Sw2,Sw1,Sw0}
//   code         target code, digit 0 in the top nibble
//   entered      correct digits so far, shifted in at LSB
//   entry_count  number of correct digits so far
//   busy         high while a code is armed
//   repaired     1-cycle pulse on full match
//   error        1-cycle pulse on wrong digit
//   timed_out    1-cycle pulse when a code expires and is replaced
interface starship_repair_lock_if #(
  parameter int unsigned NDIG = 4
);
  localparam int unsigned CW   = 4 * NDIG;
  localparam int unsigned CNTW = $clog2(NDIG + 1);

  logic            broken;
  logic            digit_valid;
  logic [3:0]      digit;
  logic [CW-1:0]   code;
  logic [CW-1:0]   entered;
  logic [CNTW-1:0] entry_count;
  logic            busy;
  logic            repaired;
  logic            error;
  logic            timed_out;

  modport master (
    output broken, digit_valid, digit,
    input  code, entered, entry_count, busy, repaired, error, timed_out
  );

  modport slave (
    input  broken, digit_valid, digit,
    output code, entered, entry_count, busy, repaired, error, timed_out
  );
endinterface

// File: rtl/starship_repair_lock.sv
// rtl/starship_repair_lock.sv - hex repair code generator and entry verifier
//
// Purpose: when a station goes broken, latch a code from a free-running
//   16-bit Galois LFSR, then check the player's nibbles in order. A full
//   match pulses repaired, a wrong nibble pulses error and restarts entry,
//   and an expired per-code timer pulses timed_out and issues a new code.
// Ports:
//   board_clk  in  system clock
//   Reset      in  asynchronous, active-high reset
//   bus        slave modport of starship_repair_lock_if (see that file)
module starship_repair_lock #(
  parameter int unsigned NDIG      = 4,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter logic [31:0] TIMEOUT   = 32'd500_000_000
) (
  input logic                   board_clk,
  input logic                   Reset,
  starship_repair_lock_if.slave bus
);

  localparam int unsigned CW   = 4 * NDIG;
  localparam int unsigned CNTW = $clog2(NDIG + 1);
  // An all-zero Galois LFSR would lock up, so a zero seed is forced to 1.
  localparam logic [15:0] SEED = (LFSR_SEED == 16'h0000) ? 16'h0001 : LFSR_SEED;
  localparam logic [15:0] LFSR_MASK = 16'hB400;

  typedef enum logic {
    S_IDLE  = 1'b0,
    S_ARMED = 1'b1
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     lfsr_q, lfsr_d;
  logic            broken_q;
  logic [31:0]     timer_q, timer_d;
  logic [CW-1:0]   code_q, code_d;
  logic [CW-1:0]   entered_q, entered_d;
  logic [CNTW-1:0] count_q, count_d;
  logic            repaired_q, repaired_d;
  logic            error_q, error_d;
  logic            timed_out_q, timed_out_d;

  logic            arm;
  logic [3:0]      expected_digit;
  logic            last_digit;

  assign arm = bus.broken & ~broken_q;

  // Nibble the player must enter next: digit 0 sits in the top nibble.
  assign expected_digit = code_q[4*(NDIG-1-int'(count_q)) +: 4];
  assign last_digit     = (count_q == CNTW'(NDIG - 1));

  assign lfsr_d = lfsr_q[0] ? ((lfsr_q >> 1) ^ LFSR_MASK) : (lfsr_q >> 1);

  always_ff @(posedge board_clk or posedge Reset) begin
    if (Reset) begin
      state_q     <= S_IDLE;
      lfsr_q      <= SEED;
      broken_q    <= 1'b0;
      timer_q     <= '0;
      code_q      <= '0;
      entered_q   <= '0;
      count_q     <= '0;
      repaired_q  <= 1'b0;
      error_q     <= 1'b0;
      timed_out_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lfsr_q      <= lfsr_d;
      broken_q    <= bus.broken;
      timer_q     <= timer_d;
      code_q      <= code_d;
      entered_q   <= entered_d;
      count_q     <= count_d;
      repaired_q  <= repaired_d;
      error_q     <= error_d;
      timed_out_q <= timed_out_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    code_d      = code_q;
    entered_d   = entered_q;
    count_d     = count_q;
    repaired_d  = 1'b0;
    error_d     = 1'b0;
    timed_out_d = 1'b0;

    unique case (state_q)
      S_IDLE: begin
        // Entries are ignored until a fresh broken edge arms a code.
        if (arm) begin
          code_d    = CW'(lfsr_q);
          entered_d = '0;
          count_d   = '0;
          timer_d   = TIMEOUT - 32'd1;
          state_d   = S_ARMED;
        end
      end

      S_ARMED: begin
        if (!bus.broken) begin
          // Station recovered by other means: drop progress, keep the code.
          entered_d = '0;
          count_d   = '0;
          state_d   = S_IDLE;
        end else if (timer_q == 32'd0) begin
          // Expiry wins over a same-cycle entry, which is dropped.
          timed_out_d = 1'b1;
          code_d      = CW'(lfsr_q);
          entered_d   = '0;
          count_d     = '0;
          timer_d     = TIMEOUT - 32'd1;
        end else if (bus.digit_valid && (bus.digit == expected_digit)) begin
          entered_d = {entered_q[CW-5:0], bus.digit};
          count_d   = count_q + CNTW'(1);
          if (last_digit) begin
            repaired_d = 1'b1;
            state_d    = S_IDLE;
          end else begin
            timer_d = timer_q - 32'd1;
          end
        end else if (bus.digit_valid) begin
          // Wrong nibble restarts entry but the code's time budget keeps running.
          error_d   = 1'b1;
          entered_d = '0;
          count_d   = '0;
          timer_d   = timer_q - 32'd1;
        end else begin
          timer_d = timer_q - 32'd1;
        end
      end

      default: state_d = S_IDLE;
    endcase
  end

  assign bus.code        = code_q;
  assign bus.entered     = entered_q;
  assign bus.entry_count = count_q;
  assign bus.busy        = (state_q == S_ARMED);
  assign bus.repaired    = repaired_q;
  assign bus.error       = error_q;
  assign bus.timed_out   = timed_out_q;

endmodule

// File: tb/tb_starship_repair_lock.sv
// tb/tb_starship_repair_lock.sv - directed self-checking bench for starship_repair_lock
//
// Purpose: three lock instances with different seeds / timeouts exercised by
//   hand-computed directed vectors.
//   dut_a: seed 0001, TIMEOUT 10 (LFSR stepping, arming, expiry)
//   dut_b: seed 3A7F, TIMEOUT 1000 (entry, error, abort, async reset)
//   dut_z: seed 0000 (zero seed replacement)
module tb_starship_repair_lock;

  logic board_clk;
  logic rst_a, rst_b, rst_z;

  int n_checks;
  int n_errors;

  starship_repair_lock_if #(.NDIG(4)) ifa ();
  starship_repair_lock_if #(.NDIG(4)) ifb ();
  starship_repair_lock_if #(.NDIG(4)) ifz ();

  starship_repair_lock #(.NDIG(4), .LFSR_SEED(16'h0001), .TIMEOUT(32'd10)) dut_a (
    .board_clk (board_clk),
    .Reset     (rst_a),
    .bus       (ifa)
  );

  starship_repair_lock #(.NDIG(4), .LFSR_SEED(16'h3A7F), .TIMEOUT(32'd1000)) dut_b (
    .board_clk (board_clk),
    .Reset     (rst_b),
    .bus       (ifb)
  );

  starship_repair_lock #(.NDIG(4), .LFSR_SEED(16'h0000), .TIMEOUT(32'd1000)) dut_z (
    .board_clk (board_clk),
    .Reset     (rst_z),
    .bus       (ifz)
  );

  initial board_clk = 1'b0;
  always #5 board_clk = ~board_clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge board_clk);
    #1;
  endtask

  task automatic send_b(input logic [3:0] d);
    ifb.digit_valid = 1'b1;
    ifb.digit       = d;
    tick();
    ifb.digit_valid = 1'b0;
  endtask

  // Reset dut_b with broken held high so it arms code 3A7F on the first clock.
  task automatic arm_b();
    rst_b = 1'b1;
    ifb.broken = 1'b1;
    ifb.digit_valid = 1'b0;
    tick();
    rst_b = 1'b0;
    tick();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst_a = 1'b1; rst_b = 1'b1; rst_z = 1'b1;
    ifa.broken = 1'b0; ifa.digit_valid = 1'b0; ifa.digit = 4'h0;
    ifb.broken = 1'b0; ifb.digit_valid = 1'b0; ifb.digit = 4'h0;
    ifz.broken = 1'b1; ifz.digit_valid = 1'b0; ifz.digit = 4'h0;
    tick();
    tick();

    // Reset state
    check_eq("rst_code",     ifa.code, 32'h0);
    check_eq("rst_entered",  ifa.entered, 32'h0);
    check_eq("rst_count",    ifa.entry_count, 32'h0);
    check_eq("rst_busy",     ifa.busy, 32'h0);
    check_eq("rst_pulses",   {ifa.repaired, ifa.error, ifa.timed_out}, 32'h0);

    // LFSR 0001 -> B400 -> 5A00; arm on the edge where lfsr = B400
    rst_a = 1'b0;
    tick();                       // lfsr 0001 -> B400, broken low
    check_eq("idle_busy", ifa.busy, 32'h0);
    ifa.broken = 1'b1;
    tick();                       // arm, code = B400, lfsr -> 5A00
    check_eq("arm_code", ifa.code, 32'hB400);
    check_eq("arm_busy", ifa.busy, 32'h1);
    ifa.broken = 1'b0;
    tick();                       // abort, lfsr 5A00 -> 2D00
    check_eq("abort_busy", ifa.busy, 32'h0);
    check_eq("abort_code_hold", ifa.code, 32'hB400);
    ifa.broken = 1'b1;
    tick();                       // re-arm with pre-step lfsr 2D00
    check_eq("rearm_code", ifa.code, 32'h2D00);

    // Timeout: arm at E0 with code 0001, expiry at E10 issues lfsr s10 = 005A
    rst_a = 1'b1;
    tick();
    rst_a = 1'b0;
    tick();                       // E0
    check_eq("to_arm_code", ifa.code, 32'h0001);
    check_eq("to_arm_busy", ifa.busy, 32'h1);
    for (int i = 1; i <= 9; i++) tick();
    check_eq("to_not_yet", ifa.timed_out, 32'h0);
    ifa.digit_valid = 1'b1;       // correct first digit, but lands on expiry
    ifa.digit = 4'h0;
    tick();                       // E10
    ifa.digit_valid = 1'b0;
    check_eq("to_pulse", ifa.timed_out, 32'h1);
    check_eq("to_new_code", ifa.code, 32'h005A);
    check_eq("to_digit_dropped", ifa.entry_count, 32'h0);
    check_eq("to_still_busy", ifa.busy, 32'h1);
    check_eq("to_no_error", ifa.error, 32'h0);
    ifa.digit_valid = 1'b1;
    ifa.digit = 4'h0;
    tick();
    ifa.digit_valid = 1'b0;
    check_eq("to_pulse_end", ifa.timed_out, 32'h0);
    check_eq("to_new_code_entry", ifa.entry_count, 32'h1);

    // Zero seed is replaced by 0001
    rst_z = 1'b0;
    tick();
    check_eq("zero_seed_code", ifz.code, 32'h0001);

    // Full correct entry
    arm_b();
    check_eq("b_code", ifb.code, 32'h3A7F);
    check_eq("b_busy", ifb.busy, 32'h1);
    send_b(4'h3);
    check_eq("ok_cnt1", ifb.entry_count, 32'h1);
    check_eq("ok_ent1", ifb.entered, 32'h0003);
    send_b(4'hA);
    check_eq("ok_cnt2", ifb.entry_count, 32'h2);
    send_b(4'h7);
    check_eq("ok_cnt3", ifb.entry_count, 32'h3);
    check_eq("ok_ent3", ifb.entered, 32'h03A7);
    check_eq("ok_not_yet", ifb.repaired, 32'h0);
    send_b(4'hF);
    check_eq("ok_repaired", ifb.repaired, 32'h1);
    check_eq("ok_entered", ifb.entered, 32'h3A7F);
    check_eq("ok_cnt4", ifb.entry_count, 32'h4);
    check_eq("ok_busy", ifb.busy, 32'h0);
    tick();
    check_eq("ok_pulse_end", ifb.repaired, 32'h0);

    // Wrong digit then retry
    arm_b();
    send_b(4'h3);
    send_b(4'hA);
    send_b(4'h5);
    check_eq("err_pulse", ifb.error, 32'h1);
    check_eq("err_cnt", ifb.entry_count, 32'h0);
    check_eq("err_entered", ifb.entered, 32'h0);
    check_eq("err_busy", ifb.busy, 32'h1);
    tick();
    check_eq("err_pulse_end", ifb.error, 32'h0);
    send_b(4'h3);
    send_b(4'hA);
    send_b(4'h7);
    send_b(4'hF);
    check_eq("retry_repaired", ifb.repaired, 32'h1);

    // Abort after two digits, then entries in IDLE are ignored
    arm_b();
    send_b(4'h3);
    send_b(4'hA);
    check_eq("ab_cnt2", ifb.entry_count, 32'h2);
    ifb.broken = 1'b0;
    tick();
    check_eq("ab_busy", ifb.busy, 32'h0);
    check_eq("ab_cnt", ifb.entry_count, 32'h0);
    check_eq("ab_entered", ifb.entered, 32'h0);
    check_eq("ab_pulses", {ifb.repaired, ifb.error, ifb.timed_out}, 32'h0);
    check_eq("ab_code_hold", ifb.code, 32'h3A7F);
    send_b(4'h7);
    send_b(4'h3);
    check_eq("idle_cnt", ifb.entry_count, 32'h0);
    check_eq("idle_pulses", {ifb.repaired, ifb.error, ifb.timed_out}, 32'h0);
    check_eq("idle_busy2", ifb.busy, 32'h0);

    // Asynchronous reset mid-entry
    arm_b();
    send_b(4'h3);
    send_b(4'hA);
    check_eq("ar_cnt2", ifb.entry_count, 32'h2);
    #2;
    rst_b = 1'b1;
    #1;
    check_eq("ar_code", ifb.code, 32'h0);
    check_eq("ar_cnt", ifb.entry_count, 32'h0);
    check_eq("ar_entered", ifb.entered, 32'h0);
    check_eq("ar_busy", ifb.busy, 32'h0);
    rst_b = 1'b0;
    ifb.broken = 1'b0;
    tick();
    check_eq("ar_idle_busy", ifb.busy, 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
